// File: rtl/sa_feeder.sv
// sa_feeder: reads weight rows then input rows from a row-wide memory and
// presents them to an N x N systolic array.
//   - PRELOAD: N weight rows at weight_base+k, shown unskewed with
//     sa_state=PRELOAD one cycle after each request.
//   - STREAM : M input rows at input_base+r. With skew enabled, lane j of a row
//     appears j cycles after lane 0 (diagonal wavefront), followed by an N-1
//     cycle DRAIN that issues no requests.
// Build option: define SA_FEEDER_SKEW_EN to build the diagonal skew registers
// and the DRAIN phase. Left undefined, all lanes of a stream row are
// presented together and DRAIN is never entered.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   start, weight_base, input_base,    job launch, sampled only when idle
//   m_len
//   mem_req, mem_addr, mem_rdata       row read port, data 1 cycle after req
//   sa_state, sa_valid, sa_lane_vld,   array feed: phase, any-live, lane mask,
//   sa_data                            lane j at [j*DATA_W +: DATA_W]
//   busy, done                         job in flight / completion pulse
//
// state      | meaning
// -----------+----------------------------------------------------------
// SA_IDLE    | no requests; may still hold the tail of the last job's lanes
// SA_PRELOAD | issuing the N weight-row reads
// SA_STREAM  | issuing the M input-row reads
// SA_DRAIN   | skew flush, N-1 cycles with no reads (skew builds only)

package sa_pkg;
    typedef enum logic [1:0] {
        SA_IDLE    = 2'd0,
        SA_PRELOAD = 2'd1,
        SA_STREAM  = 2'd2,
        SA_DRAIN   = 2'd3
    } sa_state_e;
endpackage

module sa_feeder
    import sa_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int M_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   weight_base,
    input  logic [ADDR_W-1:0]   input_base,
    input  logic [M_W-1:0]      m_len,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [N*DATA_W-1:0] mem_rdata,
    output sa_state_e           sa_state,
    output logic                sa_valid,
    output logic [N-1:0]        sa_lane_vld,
    output logic [N*DATA_W-1:0] sa_data,
    output logic                busy,
    output logic                done
);

    localparam int NB = $clog2(N + 1);
    localparam int CW = (M_W > NB) ? M_W : NB;

    sa_state_e                r_state, w_state_nxt;
    logic [CW-1:0]            r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]        r_addr, w_addr_nxt;
    logic [ADDR_W-1:0]        r_in_base, w_in_base_nxt;
    logic [M_W-1:0]           r_mlen, w_mlen_nxt;
    logic                     r_rd_vld;
    logic                     r_rd_pre;
    logic                     r_busy_d;
    logic                     w_busy;
    logic                     w_pre_vld;
    logic                     w_str_vld;
    logic [N-1:0][DATA_W-1:0] w_lane_d;
    logic [N-1:0]             w_lane_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SA_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_in_base <= '0;
            r_mlen    <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_pre  <= 1'b0;
            r_busy_d  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_addr    <= w_addr_nxt;
            r_in_base <= w_in_base_nxt;
            r_mlen    <= w_mlen_nxt;
            r_rd_vld  <= mem_req;
            r_rd_pre  <= (r_state == SA_PRELOAD);
            r_busy_d  <= w_busy;
        end
    end

    // r_cnt is a down-counter of requests (or drain cycles) still to go after
    // the current one; reaching zero marks the last cycle of the phase.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_addr_nxt    = r_addr;
        w_in_base_nxt = r_in_base;
        w_mlen_nxt    = r_mlen;
        mem_req       = 1'b0;
        mem_addr      = '0;
        case (r_state)
            SA_IDLE: begin
                // Lanes of the previous job may still be draining while the
                // FSM is idle; a start is taken only once they are gone.
                if (start && !w_busy) begin
                    w_state_nxt   = SA_PRELOAD;
                    w_cnt_nxt     = CW'(N - 1);
                    w_addr_nxt    = weight_base;
                    w_in_base_nxt = input_base;
                    w_mlen_nxt    = m_len;
                end
            end
            SA_PRELOAD: begin
                mem_req  = 1'b1;
                mem_addr = r_addr;
                if (r_cnt == '0) begin
                    if (r_mlen == '0) begin
                        w_state_nxt = SA_IDLE;
                    end else begin
                        w_state_nxt = SA_STREAM;
                        w_addr_nxt  = r_in_base;
                        w_cnt_nxt   = CW'(r_mlen - M_W'(1));
                    end
                end else begin
                    w_cnt_nxt  = r_cnt - CW'(1);
                    w_addr_nxt = r_addr + ADDR_W'(1);
                end
            end
            SA_STREAM: begin
                mem_req  = 1'b1;
                mem_addr = r_addr;
                if (r_cnt == '0) begin
`ifdef SA_FEEDER_SKEW_EN
                    if (N > 1) begin
                        w_state_nxt = SA_DRAIN;
                        w_cnt_nxt   = CW'(N - 2);
                    end else begin
                        w_state_nxt = SA_IDLE;
                    end
`else
                    w_state_nxt = SA_IDLE;
`endif
                end else begin
                    w_cnt_nxt  = r_cnt - CW'(1);
                    w_addr_nxt = r_addr + ADDR_W'(1);
                end
            end
            SA_DRAIN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = SA_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = SA_IDLE;
        endcase
    end

    // Row data arrives the cycle after its request, so lane 0 (and every
    // lane of a weight row) is passed straight through from mem_rdata.
    assign w_pre_vld   = r_rd_vld & r_rd_pre;
    assign w_str_vld   = r_rd_vld & ~r_rd_pre;
    assign w_lane_d[0] = mem_rdata[0 +: DATA_W];
    assign w_lane_v[0] = w_str_vld;

`ifdef SA_FEEDER_SKEW_EN
    // Lane j of a stream row is delayed by a j-deep register chain.
    for (genvar j = 1; j < N; j++) begin : g_skew
        logic [j-1:0][DATA_W-1:0] r_d;
        logic [j-1:0]             r_v;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_d <= '0;
                r_v <= '0;
            end else begin
                r_d[0] <= mem_rdata[j*DATA_W +: DATA_W];
                r_v[0] <= w_str_vld;
                for (int s = 1; s < j; s++) begin
                    r_d[s] <= r_d[s-1];
                    r_v[s] <= r_v[s-1];
                end
            end
        end

        assign w_lane_d[j] = r_d[j-1];
        assign w_lane_v[j] = r_v[j-1];
    end
`else
    for (genvar j = 1; j < N; j++) begin : g_align
        assign w_lane_d[j] = mem_rdata[j*DATA_W +: DATA_W];
        assign w_lane_v[j] = w_str_vld;
    end
`endif

    always_comb begin
        sa_data     = '0;
        sa_lane_vld = '0;
        for (int j = 0; j < N; j++) begin
            if (w_pre_vld) begin
                sa_lane_vld[j]               = 1'b1;
                sa_data[j*DATA_W +: DATA_W] = mem_rdata[j*DATA_W +: DATA_W];
            end else if (w_lane_v[j]) begin
                sa_lane_vld[j]               = 1'b1;
                sa_data[j*DATA_W +: DATA_W] = w_lane_d[j];
            end
        end
    end

    // sa_state describes the data currently on sa_data, so the drain tail
    // reports STREAM and cycles with no live lane report IDLE.
    always_comb begin
        if (w_pre_vld)      sa_state = SA_PRELOAD;
        else if (|w_lane_v) sa_state = SA_STREAM;
        else                sa_state = SA_IDLE;
    end

    assign sa_valid = |sa_lane_vld;
    assign w_busy   = (r_state != SA_IDLE) | sa_valid;
    assign busy     = w_busy;
    // done marks the first cycle after the job's last live lane has gone.
    assign done     = r_busy_d & ~w_busy;

endmodule

// File: tb/tb_sa_feeder.sv
module tb_sa_feeder;
    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int M_W    = 8;
    localparam int T      = 1024;
`ifdef SA_FEEDER_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   weight_base = '0;
    logic [ADDR_W-1:0]   input_base = '0;
    logic [M_W-1:0]      m_len = '0;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic [N*DATA_W-1:0] mem_rdata;
    sa_pkg::sa_state_e   sa_state;
    logic                sa_valid;
    logic [N-1:0]        sa_lane_vld;
    logic [N*DATA_W-1:0] sa_data;
    logic                busy;
    logic                done;

    sa_feeder #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .M_W(M_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .weight_base(weight_base), .input_base(input_base), .m_len(m_len),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .sa_state(sa_state), .sa_valid(sa_valid), .sa_lane_vld(sa_lane_vld),
        .sa_data(sa_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Memory contents: every lane byte is nonzero; idle-bus junk is 8'h5A.
    function automatic logic [DATA_W-1:0] f(input logic [ADDR_W-1:0] a, input int j);
        return 8'h80 | DATA_W'((int'(a) + j) & 'h7F);
    endfunction

    logic              s_req;
    logic [ADDR_W-1:0] s_addr;
    always @(negedge clk) begin
        s_req  = mem_req;
        s_addr = mem_addr;
    end
    always @(posedge clk) begin
        for (int j = 0; j < N; j++)
            mem_rdata[j*DATA_W +: DATA_W] <= s_req ? f(s_addr, j) : 8'h5A;
    end

    // Expected outputs per absolute cycle.
    logic                exp_req  [T];
    logic [ADDR_W-1:0]   exp_addr [T];
    logic [N-1:0]        exp_vld  [T];
    logic [N*DATA_W-1:0] exp_data [T];
    logic [1:0]          exp_st   [T];
    logic                exp_busy [T];
    logic                exp_done [T];

    task automatic model_clear(input int from);
        for (int t = from; t < T; t++) begin
            exp_req[t] = 0; exp_addr[t] = '0; exp_vld[t] = '0; exp_data[t] = '0;
            exp_st[t] = sa_pkg::SA_IDLE; exp_busy[t] = 0; exp_done[t] = 0;
        end
    endtask

    // Job accepted with start high in cycle c.
    task automatic model_start(input int c, input logic [ADDR_W-1:0] wb,
                               input logic [ADDR_W-1:0] ib, input int m);
        int last;
        last = 1 + N;
        for (int k = 0; k < N; k++) begin
            exp_req[c+1+k]  = 1;
            exp_addr[c+1+k] = ADDR_W'(int'(wb) + k);
            exp_vld[c+2+k]  = '1;
            exp_st[c+2+k]   = sa_pkg::SA_PRELOAD;
            for (int j = 0; j < N; j++)
                exp_data[c+2+k][j*DATA_W +: DATA_W] = f(ADDR_W'(int'(wb) + k), j);
        end
        for (int r = 0; r < m; r++) begin
            exp_req[c+1+N+r]  = 1;
            exp_addr[c+1+N+r] = ADDR_W'(int'(ib) + r);
            for (int j = 0; j < N; j++) begin
                int d;
                d = 2 + N + r + (SKEW ? j : 0);
                exp_vld[c+d][j] = 1'b1;
                exp_st[c+d]     = sa_pkg::SA_STREAM;
                exp_data[c+d][j*DATA_W +: DATA_W] = f(ADDR_W'(int'(ib) + r), j);
                if (d > last) last = d;
            end
        end
        for (int t = 1; t <= last; t++) exp_busy[c+t] = 1;
        exp_done[c+last+1] = 1;
    endtask

    always @(negedge clk) begin
        if (cyc < T) begin
            chk("mem_req", mem_req, exp_req[cyc]);
            if (exp_req[cyc]) chk("mem_addr", mem_addr, exp_addr[cyc]);
            chk("sa_lane_vld", sa_lane_vld, exp_vld[cyc]);
            chk("sa_valid", sa_valid, |exp_vld[cyc]);
            chk("sa_data", sa_data, exp_data[cyc]);
            chk("sa_state", sa_state, exp_st[cyc]);
            chk("busy", busy, exp_busy[cyc]);
            chk("done", done, exp_done[cyc]);
        end
    end

    // Raw observation log for the hand-computed checks.
    logic [ADDR_W-1:0] q_addr[$];
    int                q_rc[$];
    int n_done = 0, done_cyc = 0, last_l3 = 0, n_pre = 0;
    bit saw_str = 0;
    always @(negedge clk) begin
        if (mem_req) begin q_addr.push_back(mem_addr); q_rc.push_back(cyc); end
        if (done) begin n_done++; done_cyc = cyc; end
        if (sa_lane_vld[3]) last_l3 = cyc;
        if (sa_state == sa_pkg::SA_PRELOAD && sa_valid) n_pre++;
        if (sa_state == sa_pkg::SA_STREAM) saw_str = 1;
    end

    task automatic clr_log();
        q_addr.delete(); q_rc.delete();
        n_done = 0; n_pre = 0; saw_str = 0;
    endtask

    task automatic chk_addrs(input string nm, input logic [ADDR_W-1:0] lit[$]);
        chk({nm, "_nreq"}, q_addr.size(), lit.size());
        for (int i = 0; i < lit.size(); i++)
            chk($sformatf("%s_addr%0d", nm, i), (i < q_addr.size()) ? q_addr[i] : '1, lit[i]);
    endtask

    task automatic go(input logic [ADDR_W-1:0] wb, input logic [ADDR_W-1:0] ib, input int m);
        @(posedge clk); #1;
        start = 1; weight_base = wb; input_base = ib; m_len = M_W'(m);
        if (!exp_busy[cyc]) model_start(cyc, wb, ib, m);
        @(posedge clk); #1;
        start = 0;
    endtask

    logic [ADDR_W-1:0] lit[$];
    int c42;

    initial begin
        model_clear(0);
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_sa_data", sa_data, 0);
        chk("rst_sa_state", sa_state, sa_pkg::SA_IDLE);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(posedge clk);

        // Basic job.
        clr_log();
        go(10'h010, 10'h040, 3);
        repeat (16) @(posedge clk);
        lit = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h040, 10'h041, 10'h042};
        chk_addrs("jobA", lit);
        chk("jobA_consec", q_rc[q_rc.size()-1] - q_rc[0], 6);
        chk("jobA_ndone", n_done, 1);
        c42 = q_rc[q_rc.size()-1];
        chk("jobA_l3_lat", last_l3 - c42, SKEW ? 4 : 1);
        chk("jobA_done_lat", done_cyc - c42, SKEW ? 5 : 2);

        // Weights only.
        clr_log();
        go(10'h020, 10'h030, 0);
        repeat (12) @(posedge clk);
        chk("m0_nreq", q_addr.size(), 4);
        chk("m0_npre", n_pre, 4);
        chk("m0_ndone", n_done, 1);
        chk("m0_nostream", saw_str, 0);
        chk("m0_done_lat", done_cyc - q_rc[q_rc.size()-1], 2);

        // Address wrap.
        clr_log();
        go(10'h3FE, 10'h3FF, 2);
        repeat (16) @(posedge clk);
        lit = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h3FF, 10'h000};
        chk_addrs("wrap", lit);

        // Start pulsed while streaming is ignored.
        clr_log();
        go(10'h050, 10'h060, 5);
        repeat (4) @(posedge clk);
        go(10'h100, 10'h200, 1);
        repeat (20) @(posedge clk);
        lit = '{10'h050, 10'h051, 10'h052, 10'h053,
                10'h060, 10'h061, 10'h062, 10'h063, 10'h064};
        chk_addrs("busy_start", lit);
        chk("busy_start_ndone", n_done, 1);

        // One-cycle reset mid-stream, then a fresh job.
        clr_log();
        go(10'h070, 10'h080, 4);
        repeat (5) @(posedge clk);
        #1 rst_n = 0;
        model_clear(cyc);
        @(negedge clk);
        chk("midrst_sa_data", sa_data, 0);
        chk("midrst_mem_req", mem_req, 0);
        @(posedge clk); #1 rst_n = 1;
        repeat (10) @(posedge clk);
        chk("midrst_nodone", n_done, 0);
        clr_log();
        go(10'h090, 10'h0A0, 2);
        repeat (16) @(posedge clk);
        lit = '{10'h090, 10'h091, 10'h092, 10'h093, 10'h0A0, 10'h0A1};
        chk_addrs("after_rst", lit);
        chk("after_rst_ndone", n_done, 1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
